// File: rtl/uart_param_regs.sv
// Decodes UART command frames into shadow frequency registers and commits
// them atomically to the active DDS sweep/hop outputs when the DDS is idle.
module uart_param_regs #(
  parameter int MAX_FREQ_MHZ   = 1740,
  parameter int DEFAULT_FREQ_L = 430,
  parameter int DEFAULT_FREQ_U = 470,
  parameter int DEFAULT_FREQ_H = 900,
  parameter int COMMIT_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_last,
  input  logic        crc_err,
  input  logic        dds_busy,
  output logic [31:0] freq_l,
  output logic [31:0] freq_u,
  output logic [31:0] freq_h,
  output logic        param_update,
  output logic [7:0]  err_count,
  output logic [2:0]  err_code
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_CHECK,
    S_COMMIT_WAIT
  } state_e;

  localparam logic [7:0] OP_SET_L = 8'h01;
  localparam logic [7:0] OP_SET_U = 8'h02;
  localparam logic [7:0] OP_SET_H = 8'h03;
  localparam logic [7:0] OP_APPLY = 8'h04;

  localparam logic [2:0] ERR_OPCODE  = 3'd1;
  localparam logic [2:0] ERR_LENGTH  = 3'd2;
  localparam logic [2:0] ERR_CRC     = 3'd3;
  localparam logic [2:0] ERR_RANGE   = 3'd4;
  localparam logic [2:0] ERR_ORDER   = 3'd5;
  localparam logic [2:0] ERR_TIMEOUT = 3'd6;
  localparam logic [2:0] ERR_DROPPED = 3'd7;

  localparam int              TW         = $clog2(COMMIT_TIMEOUT + 1);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(COMMIT_TIMEOUT - 1);
  localparam logic [31:0]     MAX_FREQ   = 32'(MAX_FREQ_MHZ);
  localparam logic [31:0]     RST_L      = 32'(DEFAULT_FREQ_L);
  localparam logic [31:0]     RST_U      = 32'(DEFAULT_FREQ_U);
  localparam logic [31:0]     RST_H      = 32'(DEFAULT_FREQ_H);

  state_e        state;
  logic [7:0]    opcode;
  logic [2:0]    byte_cnt;
  logic [31:0]   acc;
  logic          crc_flag;
  logic [31:0]   shadow_l;
  logic [31:0]   shadow_u;
  logic [31:0]   shadow_h;
  logic [TW-1:0] timer;
  logic          drop_busy;   // a frame that began while busy is still streaming in
  logic [2:0]    drop_owed;   // dropped frames whose rejection is not yet recorded

  logic          is_set;
  logic          is_apply;
  logic [2:0]    exp_cnt;
  logic          chk_fail;
  logic [2:0]    chk_code;
  logic          in_busy;
  logic          drop_byte;
  logic          drop_end;
  logic          drain;
  logic [2:0]    owed_next;
  logic          timeout_hit;
  logic          rej_fire;
  logic [2:0]    rej_code;

  // Frame validation, evaluated while the FSM sits in CHECK.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    is_set   = (opcode == OP_SET_L) || (opcode == OP_SET_U) || (opcode == OP_SET_H);
    is_apply = (opcode == OP_APPLY);
    exp_cnt  = is_apply ? 3'd0 : 3'd4;
    chk_fail = 1'b0;
    chk_code = 3'd0;
    if (crc_flag) begin
      chk_fail = 1'b1;
      chk_code = ERR_CRC;
    end else if (!is_set && !is_apply) begin
      chk_fail = 1'b1;
      chk_code = ERR_OPCODE;
    end else if (byte_cnt != exp_cnt) begin
      chk_fail = 1'b1;
      chk_code = ERR_LENGTH;
    end else if (is_set && (acc > MAX_FREQ)) begin
      chk_fail = 1'b1;
      chk_code = ERR_RANGE;
    end else if (is_apply && (shadow_l > shadow_u)) begin
      chk_fail = 1'b1;
      chk_code = ERR_ORDER;
    end
  end

  // Dropped-frame bookkeeping and the single reject source per cycle. Rejects
  // from CHECK and COMMIT_WAIT never overlap with draining owed code-7 rejects,
  // because owed rejects are only recorded in IDLE/PAYLOAD.
  always_comb begin
    in_busy   = (state == S_CHECK) || (state == S_COMMIT_WAIT);
    drop_byte = cmd_valid && (in_busy || drop_busy);
    drop_end  = drop_byte && cmd_last;
    drain     = (drop_owed != 3'd0) && !in_busy;
    owed_next = drop_owed;
    if (drop_end && !drain && (drop_owed != 3'd7)) begin
      owed_next = drop_owed + 3'd1;
    end else if (!drop_end && drain) begin
      owed_next = drop_owed - 3'd1;
    end
    timeout_hit = (state == S_COMMIT_WAIT) && dds_busy && (timer == TIMER_LAST);
    rej_fire    = 1'b0;
    rej_code    = 3'd0;
    if ((state == S_CHECK) && chk_fail) begin
      rej_fire = 1'b1;
      rej_code = chk_code;
    end else if (timeout_hit) begin
      rej_fire = 1'b1;
      rej_code = ERR_TIMEOUT;
    end else if (drain) begin
      rej_fire = 1'b1;
      rej_code = ERR_DROPPED;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      opcode       <= 8'h00;
      byte_cnt     <= 3'd0;
      acc          <= 32'd0;
      crc_flag     <= 1'b0;
      shadow_l     <= RST_L;
      shadow_u     <= RST_U;
      shadow_h     <= RST_H;
      freq_l       <= RST_L;
      freq_u       <= RST_U;
      freq_h       <= RST_H;
      timer        <= '0;
      drop_busy    <= 1'b0;
      drop_owed    <= 3'd0;
      param_update <= 1'b0;
      err_count    <= 8'd0;
      err_code     <= 3'd0;
    end else begin
      param_update <= 1'b0;
      drop_owed    <= owed_next;
      if (drop_byte) begin
        drop_busy <= !cmd_last;
      end
      if (rej_fire) begin
        err_code <= rej_code;
        if (err_count != 8'hFF) begin
          err_count <= err_count + 8'd1;
        end
      end

      case (state)
        S_IDLE: begin
          if (cmd_valid && !drop_busy) begin
            opcode   <= cmd_data;
            byte_cnt <= 3'd0;
            acc      <= 32'd0;
            crc_flag <= cmd_last && crc_err;
            state    <= cmd_last ? S_CHECK : S_PAYLOAD;
          end
        end

        S_PAYLOAD: begin
          if (cmd_valid) begin
            acc <= {acc[23:0], cmd_data};
            if (byte_cnt != 3'd7) begin
              byte_cnt <= byte_cnt + 3'd1;
            end
            if (cmd_last) begin
              crc_flag <= crc_err;
              state    <= S_CHECK;
            end
          end
        end

        S_CHECK: begin
          timer <= '0;
          state <= S_IDLE;
          if (!chk_fail) begin
            case (opcode)
              OP_SET_L: shadow_l <= acc;
              OP_SET_U: shadow_u <= acc;
              OP_SET_H: shadow_h <= acc;
              OP_APPLY: state    <= S_COMMIT_WAIT;
              default:  ;
            endcase
          end
        end

        S_COMMIT_WAIT: begin
          if (!dds_busy) begin
            freq_l       <= shadow_l;
            freq_u       <= shadow_u;
            freq_h       <= shadow_h;
            param_update <= 1'b1;
            state        <= S_IDLE;
          end else if (timer == TIMER_LAST) begin
            state <= S_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_param_regs.sv
// Directed bench for uart_param_regs: frame decode, rejects, commit handshake,
// timeout, dropped frames, error saturation and asynchronous reset.
module tb_uart_param_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_data = 8'h00;
  logic        cmd_last = 1'b0;
  logic        crc_err = 1'b0;
  logic        dds_busy = 1'b0;
  logic [31:0] freq_l;
  logic [31:0] freq_u;
  logic [31:0] freq_h;
  logic        param_update;
  logic [7:0]  err_count;
  logic [2:0]  err_code;

  int n_checks = 0;
  int n_fail   = 0;
  int at;
  int pulses;

  uart_param_regs dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_data     (cmd_data),
    .cmd_last     (cmd_last),
    .crc_err      (crc_err),
    .dds_busy     (dds_busy),
    .freq_l       (freq_l),
    .freq_u       (freq_u),
    .freq_h       (freq_h),
    .param_update (param_update),
    .err_count    (err_count),
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input logic last, input logic crc);
    cmd_valid = 1'b1;
    cmd_data  = b;
    cmd_last  = last;
    crc_err   = crc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    cmd_last  = 1'b0;
    crc_err   = 1'b0;
  endtask

  // Bytes are right-aligned in 'bytes'; the first byte sent is the most significant.
  task automatic send_frame(input logic [127:0] bytes, input int n, input logic crc);
    for (int i = 0; i < n; i++) begin
      send_byte(bytes[8*(n-1-i) +: 8], (i == n - 1), crc && (i == n - 1));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(input int budget, output int first);
    first = -1;
    for (int k = 1; k <= budget && first < 0; k++) begin
      @(posedge clk);
      #1;
      if (param_update) first = k;
    end
  endtask

  task automatic count_pulses(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (param_update) cnt++;
    end
  endtask

  initial begin
    // Reset state
    idle(2);
    check("rst_freq_l", freq_l, 430);
    check("rst_freq_u", freq_u, 470);
    check("rst_freq_h", freq_h, 900);
    check("rst_update", 32'(param_update), 0);
    check("rst_err_count", 32'(err_count), 0);
    check("rst_err_code", 32'(err_code), 0);
    rst = 1'b1;
    idle(2);

    // L=500 above default U=470: APPLY rejected with code 5
    send_frame(128'h01_0000_01F4, 5, 1'b0);
    idle(1);
    send_frame(128'h04, 1, 1'b0);
    idle(1);
    check("order_err_code", 32'(err_code), 5);
    check("order_err_count", 32'(err_count), 1);
    count_pulses(4, pulses);
    check("order_no_pulse", 32'(pulses), 0);
    check("order_freq_l", freq_l, 430);

    // U=600, L=500, APPLY with busy low: pulse 2 cycles after last byte
    send_frame(128'h02_0000_0258, 5, 1'b0);
    idle(1);
    send_frame(128'h01_0000_01F4, 5, 1'b0);
    idle(1);
    send_frame(128'h04, 1, 1'b0);
    wait_pulse(4, at);
    check("apply_latency", 32'(at), 2);
    check("apply_freq_l", freq_l, 500);
    check("apply_freq_u", freq_u, 600);
    check("apply_freq_h", freq_h, 900);
    idle(1);
    check("apply_pulse_width", 32'(param_update), 0);

    // H=2000 out of range: code 4, shadow H untouched
    send_frame(128'h03_0000_07D0, 5, 1'b0);
    idle(1);
    check("range_err_code", 32'(err_code), 4);
    check("range_err_count", 32'(err_count), 2);
    send_frame(128'h04, 1, 1'b0);
    wait_pulse(4, at);
    check("range_apply_latency", 32'(at), 2);
    check("range_freq_h", freq_h, 900);

    // CRC error on L=100: code 3, shadow L stays 500
    send_frame(128'h01_0000_0064, 5, 1'b1);
    idle(1);
    check("crc_err_code", 32'(err_code), 3);
    check("crc_err_count", 32'(err_count), 3);
    send_frame(128'h04, 1, 1'b0);
    wait_pulse(4, at);
    check("crc_apply_latency", 32'(at), 2);
    check("crc_freq_l", freq_l, 500);

    // Unknown opcode
    send_frame(128'h05, 1, 1'b0);
    idle(1);
    check("opcode_err_code", 32'(err_code), 1);
    check("opcode_err_count", 32'(err_count), 4);

    // Length errors: short set, 12-byte payload (counter saturates), APPLY with payload
    send_frame(128'h01_0001, 3, 1'b0);
    idle(1);
    check("short_err_code", 32'(err_code), 2);
    check("short_err_count", 32'(err_count), 5);
    send_frame(128'h01_00000000000000000000000A, 13, 1'b0);
    idle(1);
    check("long_err_code", 32'(err_code), 2);
    check("long_err_count", 32'(err_count), 6);
    send_frame(128'h04_00, 2, 1'b0);
    idle(1);
    check("apply_len_err_code", 32'(err_code), 2);
    check("apply_len_err_count", 32'(err_count), 7);

    // Range boundary: 1740 accepted, 1741 rejected
    send_frame(128'h01_0000_06CC, 5, 1'b0);
    idle(1);
    check("max_ok_err_count", 32'(err_count), 7);
    send_frame(128'h03_0000_06CD, 5, 1'b0);
    idle(1);
    check("max_plus1_err_code", 32'(err_code), 4);
    check("max_plus1_err_count", 32'(err_count), 8);

    // Timeout: busy held for the whole window
    send_frame(128'h01_0000_012C, 5, 1'b0);
    idle(1);
    dds_busy = 1'b1;
    send_frame(128'h04, 1, 1'b0);
    count_pulses(1024, pulses);
    check("timeout_not_yet", 32'(err_code), 4);
    idle(1);
    check("timeout_err_code", 32'(err_code), 6);
    check("timeout_err_count", 32'(err_count), 9);
    check("timeout_no_pulse", 32'(pulses), 0);
    check("timeout_freq_l", freq_l, 500);

    // Busy released after 300 cycles: commit on the first edge it is seen low
    send_frame(128'h04, 1, 1'b0);
    count_pulses(300, pulses);
    check("late_no_early_pulse", 32'(pulses), 0);
    dds_busy = 1'b0;
    wait_pulse(3, at);
    check("late_pulse_at", 32'(at), 1);
    check("late_freq_l", freq_l, 300);
    check("late_freq_u", freq_u, 600);
    check("late_err_count", 32'(err_count), 9);

    // Frame arriving during COMMIT_WAIT is dropped and rejected with code 7
    dds_busy = 1'b1;
    send_frame(128'h04, 1, 1'b0);
    send_frame(128'h01_0000_000A, 5, 1'b0);
    dds_busy = 1'b0;
    wait_pulse(3, at);
    check("drop_commit_at", 32'(at), 1);
    idle(1);
    check("drop_err_code", 32'(err_code), 7);
    check("drop_err_count", 32'(err_count), 10);
    check("drop_freq_l", freq_l, 300);

    // err_count saturation
    for (int i = 0; i < 256; i++) begin
      send_frame(128'h05, 1, 1'b0);
      idle(1);
    end
    check("sat_err_count", 32'(err_count), 255);
    check("sat_err_code", 32'(err_code), 1);

    // Asynchronous reset while waiting to commit
    dds_busy = 1'b1;
    send_frame(128'h04, 1, 1'b0);
    idle(5);
    #3;
    rst = 1'b0;
    #1;
    check("arst_freq_l", freq_l, 430);
    check("arst_freq_u", freq_u, 470);
    check("arst_freq_h", freq_h, 900);
    check("arst_err_count", 32'(err_count), 0);
    check("arst_err_code", 32'(err_code), 0);
    dds_busy = 1'b0;
    count_pulses(3, pulses);
    rst = 1'b1;
    count_pulses(5, at);
    check("arst_no_pulse", 32'(pulses + at), 0);

    // Shadows were reset too: APPLY commits defaults
    send_frame(128'h04, 1, 1'b0);
    wait_pulse(4, at);
    check("post_rst_apply_at", 32'(at), 2);
    check("post_rst_freq_l", freq_l, 430);
    check("post_rst_freq_u", freq_u, 470);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
